// File: rtl/fft_frame_sequencer_pkg.sv
// Shared constants, state encodings and a packing helper for the FFT frame
// sequencer. The core takes two complex points per cycle, so a frame of
// N_POINTS real samples is held as PAIRS words of two samples each.
package fft_seq_pkg;

  localparam int N_POINTS = 1024;
  localparam int DW       = 16;
  localparam int PAIRS    = N_POINTS / 2;
  // Sample counter spans 0..N_POINTS, so it needs one bit above the index
  localparam int CNT_W    = $clog2(N_POINTS) + 1;
  localparam int BIN_W    = $clog2(PAIRS);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2
  } in_state_e;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_RUN  = 1'b1
  } out_state_e;

  // Two consecutive samples share one buffer word, even sample in the low half
  function automatic logic [2*DW-1:0] pack_pair(input logic [DW-1:0] even,
                                                input logic [DW-1:0] odd);
    return {odd, even};
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Stream bundle for the FFT frame sequencer.
//   s_valid/s_ready/s_data : real sample stream into the sequencer
//   m_valid, m_re0, m_im0, m_re1, m_im1, m_bin, m_last : spectrum stream out,
//     two bins (2*m_bin, 2*m_bin+1) per beat, no backpressure
// master = sample source / spectrum sink, slave = the sequencer.
interface fft_frame_sequencer_if;
  import fft_seq_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;

  logic             m_valid;
  logic [DW-1:0]    m_re0;
  logic [DW-1:0]    m_im0;
  logic [DW-1:0]    m_re1;
  logic [DW-1:0]    m_im1;
  logic [BIN_W-1:0] m_bin;
  logic             m_last;

  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_re0, m_im0, m_re1, m_im1, m_bin, m_last
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_re0, m_im0, m_re1, m_im1, m_bin, m_last
  );

endinterface

// File: rtl/fft_frame_sequencer_frame_buf.sv
// frame_buf: simple dual-port RAM holding one frame of packed sample pairs.
//   clk   : write and read clock
//   we    : write enable, waddr/wdata : write port
//   raddr : read address, rdata : registered read data (1-cycle latency)
// Contents have no reset; the sequencer only reads words it has written.
module frame_buf
  import fft_seq_pkg::*;
#(
  parameter int DEPTH = PAIRS,
  parameter int WIDTH = 2 * DW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: collects real audio samples into N_POINTS-point frames,
// feeds them to a streaming FFT core two points per cycle, and captures the
// core's output frame into a spectrum stream.
//   clk, reset (sync, active-low), enable (stop accepting after current frame)
//   sbus        : sample stream in / spectrum stream out (interface, slave)
//   fft_reset   : active-high core reset, held one cycle past reset release
//   fft_next    : one-cycle frame-start pulse to the core
//   fft_x0..x3  : core inputs (real even, imag even, real odd, imag odd)
//   fft_next_out, fft_y0..y3 : core output-frame pulse and data
//   busy        : frame partly filled, being issued, or output being captured
//   err_overlap : sticky, core started a new output frame during capture
module fft_frame_sequencer
  import fft_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  fft_frame_sequencer_if.slave  sbus,
  output logic                  fft_reset,
  output logic                  fft_next,
  output logic [DW-1:0]         fft_x0,
  output logic [DW-1:0]         fft_x1,
  output logic [DW-1:0]         fft_x2,
  output logic [DW-1:0]         fft_x3,
  input  logic                  fft_next_out,
  input  logic [DW-1:0]         fft_y0,
  input  logic [DW-1:0]         fft_y1,
  input  logic [DW-1:0]         fft_y2,
  input  logic [DW-1:0]         fft_y3,
  output logic                  busy,
  output logic                  err_overlap
);

  // Input side
  in_state_e        in_state_q, in_state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DW-1:0]    even_q, even_d;
  logic [BIN_W-1:0] rd_idx_q, rd_idx_d;
  logic             fft_next_q, fft_next_d;
  logic             accept;
  logic             wr_en;
  logic [BIN_W-1:0] wr_addr;
  logic [BIN_W-1:0] rd_addr;
  logic [2*DW-1:0]  wr_data;
  logic [2*DW-1:0]  rd_data;

  // Core reset stretcher
  logic             fft_reset_q;
  logic             rst_hold_q;

  // Output side
  out_state_e       out_state_q, out_state_d;
  logic [BIN_W-1:0] cap_idx_q, cap_idx_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [BIN_W-1:0] m_bin_q, m_bin_d;
  logic [DW-1:0]    m_re0_q, m_re0_d;
  logic [DW-1:0]    m_im0_q, m_im0_d;
  logic [DW-1:0]    m_re1_q, m_re1_d;
  logic [DW-1:0]    m_im1_q, m_im1_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Ready only while filling; forced low while the block is held in reset
  assign sbus.s_ready = reset & enable & (in_state_q == FILL);
  assign accept       = sbus.s_valid & sbus.s_ready;

  frame_buf #(
    .DEPTH (PAIRS),
    .WIDTH (2 * DW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Input FSM next state: fill buffer, pulse frame start, stream words out
  always_comb begin
    in_state_d = in_state_q;
    count_d    = count_q;
    even_d     = even_q;
    rd_idx_d   = rd_idx_q;
    fft_next_d = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = count_q[CNT_W-2:1];
    wr_data    = pack_pair(even_q, sbus.s_data);
    // Read one word ahead so the registered RAM output lines up with the drive cycle
    rd_addr    = rd_idx_q + BIN_W'(1);
    case (in_state_q)
      FILL: begin
        if (accept) begin
          count_d = count_q + CNT_W'(1);
          if (count_q[0] == 1'b0) begin
            even_d = sbus.s_data;
          end else begin
            wr_en = 1'b1;
          end
          if (count_q == CNT_W'(N_POINTS - 1)) begin
            in_state_d = START;
            fft_next_d = 1'b1;
          end else begin
            in_state_d = FILL;
          end
        end else begin
          in_state_d = FILL;
        end
      end
      START: begin
        in_state_d = STREAM;
        rd_idx_d   = '0;
        rd_addr    = '0;
      end
      STREAM: begin
        if (rd_idx_q == BIN_W'(PAIRS - 1)) begin
          in_state_d = FILL;
          count_d    = '0;
        end else begin
          rd_idx_d = rd_idx_q + BIN_W'(1);
        end
      end
      default: begin
        in_state_d = FILL;
        count_d    = '0;
      end
    endcase
  end

  // Input FSM state and registered frame-start pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_state_q <= FILL;
      count_q    <= '0;
      even_q     <= '0;
      rd_idx_q   <= '0;
      fft_next_q <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      count_q    <= count_d;
      even_q     <= even_d;
      rd_idx_q   <= rd_idx_d;
      fft_next_q <= fft_next_d;
    end
  end

  // Core reset follows the block reset and stays high one cycle after release
  always_ff @(posedge clk) begin
    if (!reset) begin
      fft_reset_q <= 1'b1;
      rst_hold_q  <= 1'b1;
    end else begin
      fft_reset_q <= rst_hold_q;
      rst_hold_q  <= 1'b0;
    end
  end

  // Core data lines carry RAM output only while streaming; imaginary parts are zero
  always_comb begin
    if (in_state_q == STREAM) begin
      fft_x0 = rd_data[DW-1:0];
      fft_x2 = rd_data[2*DW-1:DW];
    end else begin
      fft_x0 = '0;
      fft_x2 = '0;
    end
    fft_x1 = '0;
    fft_x3 = '0;
  end

  // Output FSM next state: capture one core output word per cycle
  always_comb begin
    out_state_d = out_state_q;
    cap_idx_d   = cap_idx_q;
    m_valid_d   = 1'b0;
    m_last_d    = 1'b0;
    m_bin_d     = m_bin_q;
    m_re0_d     = m_re0_q;
    m_im0_d     = m_im0_q;
    m_re1_d     = m_re1_q;
    m_im1_d     = m_im1_q;
    err_d       = err_q;
    case (out_state_q)
      O_IDLE: begin
        if (fft_next_out) begin
          out_state_d = O_RUN;
          cap_idx_d   = '0;
        end else begin
          out_state_d = O_IDLE;
        end
      end
      O_RUN: begin
        m_valid_d = 1'b1;
        m_bin_d   = cap_idx_q;
        m_re0_d   = fft_y0;
        m_im0_d   = fft_y1;
        m_re1_d   = fft_y2;
        m_im1_d   = fft_y3;
        // A new core frame mid-capture is flagged but does not restart capture
        if (fft_next_out) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (cap_idx_q == BIN_W'(PAIRS - 1)) begin
          m_last_d    = 1'b1;
          out_state_d = O_IDLE;
        end else begin
          cap_idx_d = cap_idx_q + BIN_W'(1);
        end
      end
      default: begin
        out_state_d = O_IDLE;
      end
    endcase
  end

  // Busy reflects the state being entered so the registered flag matches it
  always_comb begin
    if ((in_state_d != FILL) || (count_d != '0) || (out_state_d == O_RUN)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Output FSM state, spectrum registers and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_state_q <= O_IDLE;
      cap_idx_q   <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_bin_q     <= '0;
      m_re0_q     <= '0;
      m_im0_q     <= '0;
      m_re1_q     <= '0;
      m_im1_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      cap_idx_q   <= cap_idx_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_bin_q     <= m_bin_d;
      m_re0_q     <= m_re0_d;
      m_im0_q     <= m_im0_d;
      m_re1_q     <= m_re1_d;
      m_im1_q     <= m_im1_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign fft_reset    = fft_reset_q;
  assign fft_next     = fft_next_q;
  assign busy         = busy_q;
  assign err_overlap  = err_q;
  assign sbus.m_valid = m_valid_q;
  assign sbus.m_last  = m_last_q;
  assign sbus.m_bin   = m_bin_q;
  assign sbus.m_re0   = m_re0_q;
  assign sbus.m_im0   = m_im0_q;
  assign sbus.m_re1   = m_re1_q;
  assign sbus.m_im1   = m_im1_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed, scoreboard-based bench for fft_frame_sequencer.
module tb_fft_frame_sequencer;
  import fft_seq_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fft_next_out;
  logic [DW-1:0] fft_y0, fft_y1, fft_y2, fft_y3;
  logic          fft_reset, fft_next, busy, err_overlap;
  logic [DW-1:0] fft_x0, fft_x1, fft_x2, fft_x3;

  fft_frame_sequencer_if bus ();

  fft_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sbus         (bus),
    .fft_reset    (fft_reset),
    .fft_next     (fft_next),
    .fft_x0       (fft_x0),
    .fft_x1       (fft_x1),
    .fft_x2       (fft_x2),
    .fft_x3       (fft_x3),
    .fft_next_out (fft_next_out),
    .fft_y0       (fft_y0),
    .fft_y1       (fft_y1),
    .fft_y2       (fft_y2),
    .fft_y3       (fft_y3),
    .busy         (busy),
    .err_overlap  (err_overlap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // scoreboards
  logic [2*DW-1:0] exp_words[$];
  logic [73:0]     exp_m[$];
  logic [DW-1:0]   even_hold = '0;
  bit              odd_phase = 1'b0;
  bit              took = 1'b0;
  bit              stream_on = 1'b0;
  int              k = 0;
  int              next_cnt = 0;
  int              last_next_cyc = -1;
  int              spacing_q[$];
  int              low_run = 0;
  int              low_runs[$];
  int              mv_cnt = 0, last_cnt = 0, first_mv_cyc = -1, last_mv_cyc = -1;
  int              pat = 0, gen_idx = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] gen();
    logic [DW-1:0] v;
    if (pat == 0) begin
      case (gen_idx)
        0:       v = 16'hFFFF;
        1:       v = 16'd2;
        2:       v = 16'd3;
        default: v = 16'd0;
      endcase
    end else begin
      v = DW'($urandom_range(0, 65535));
    end
    gen_idx++;
    return v;
  endfunction

  // observe the current cycle at the falling edge, then advance to just after the rising edge
  task automatic monitor();
    logic [2*DW-1:0] w;
    logic [73:0]     em;
    if (reset && bus.s_valid && bus.s_ready) begin
      took = 1'b1;
      if (!odd_phase) even_hold = bus.s_data;
      else exp_words.push_back({bus.s_data, even_hold});
      odd_phase = !odd_phase;
    end
    if (stream_on) begin
      if (exp_words.size() == 0) begin
        chk("x_underflow", longint'(exp_words.size()), 64'd1);
      end else begin
        w = exp_words.pop_front();
        chk("x_word", longint'({fft_x3, fft_x2, fft_x1, fft_x0}),
            longint'({16'h0, w[2*DW-1:DW], 16'h0, w[DW-1:0]}));
      end
      k++;
      if (k == PAIRS) stream_on = 1'b0;
    end else begin
      chk("x_idle", longint'({fft_x3, fft_x2, fft_x1, fft_x0}), 64'd0);
    end
    if (fft_next === 1'b1) begin
      next_cnt++;
      if (last_next_cyc >= 0) spacing_q.push_back(cyc - last_next_cyc);
      last_next_cyc = cyc;
      stream_on = 1'b1;
      k = 0;
    end
    if (reset && enable) begin
      if (bus.s_ready === 1'b0) begin
        low_run++;
      end else if (low_run > 0) begin
        low_runs.push_back(low_run);
        low_run = 0;
      end
    end
    if (bus.m_valid === 1'b1) begin
      if (exp_m.size() == 0) begin
        chk("m_underflow", longint'(exp_m.size()), 64'd1);
      end else begin
        em = exp_m.pop_front();
        chk_m("m_beat", {bus.m_bin, bus.m_last, bus.m_re0, bus.m_im0, bus.m_re1, bus.m_im1}, em);
      end
      mv_cnt++;
      if (bus.m_last === 1'b1) last_cnt++;
      if (first_mv_cyc < 0) first_mv_cyc = cyc;
      last_mv_cyc = cyc;
    end
    if (!reset) begin
      stream_on = 1'b0;
      exp_words.delete();
      exp_m.delete();
      odd_phase = 1'b0;
      low_run = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic feed(input int n, input int maxc);
    int got = 0;
    int used = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = gen();
    while (got < n && used < maxc) begin
      took = 1'b0;
      tick();
      used++;
      if (took) begin
        got++;
        if (got < n) bus.s_data = gen();
      end
    end
    bus.s_valid = 1'b0;
    chk("feed_count", longint'(got), longint'(n));
  endtask

  task automatic core_frame(input int ovl_at);
    int pulse_cyc;
    mv_cnt = 0; last_cnt = 0; first_mv_cyc = -1; last_mv_cyc = -1;
    fft_next_out = 1'b1;
    pulse_cyc = cyc;
    tick();
    for (int j = 0; j < PAIRS; j++) begin
      fft_y0 = DW'(4 * j);
      fft_y1 = DW'(4 * j + 1);
      fft_y2 = DW'(4 * j + 2);
      fft_y3 = DW'(4 * j + 3);
      exp_m.push_back({BIN_W'(j), (j == PAIRS - 1), fft_y0, fft_y1, fft_y2, fft_y3});
      fft_next_out = (j == ovl_at);
      tick();
    end
    fft_next_out = 1'b0;
    fft_y0 = '0; fft_y1 = '0; fft_y2 = '0; fft_y3 = '0;
    repeat (4) tick();
    chk("m_count", longint'(mv_cnt), longint'(PAIRS));
    chk("m_last_count", longint'(last_cnt), 64'd1);
    chk("m_first_latency", longint'(first_mv_cyc - pulse_cyc), 64'd2);
    chk("m_last_latency", longint'(last_mv_cyc - pulse_cyc), 64'd513);
    chk("m_queue_empty", longint'(exp_m.size()), 64'd0);
  endtask

  int base;

  initial begin
    reset = 1'b0; enable = 1'b1; fft_next_out = 1'b0;
    fft_y0 = '0; fft_y1 = '0; fft_y2 = '0; fft_y3 = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    tick();
    mon_en = 1'b1;
    tick();
    // reset state
    chk("rst_s_ready", longint'(bus.s_ready), 64'd0);
    chk("rst_fft_next", longint'(fft_next), 64'd0);
    chk("rst_fft_reset", longint'(fft_reset), 64'd1);
    chk("rst_m_valid", longint'(bus.m_valid), 64'd0);
    chk_m("rst_m_fields", {bus.m_bin, bus.m_last, bus.m_re0, bus.m_im0, bus.m_re1, bus.m_im1}, 74'd0);
    chk("rst_busy", longint'(busy), 64'd0);
    chk("rst_err", longint'(err_overlap), 64'd0);
    reset = 1'b1;
    tick();
    chk("fft_reset_stretch", longint'(fft_reset), 64'd1);
    tick();
    chk("fft_reset_release", longint'(fft_reset), 64'd0);
    chk("s_ready_fill", longint'(bus.s_ready), 64'd1);

    // first frame: -1, 2, 3, then zeros
    pat = 0; gen_idx = 0;
    feed(N_POINTS, 2000);
    chk("busy_after_fill", longint'(busy), 64'd1);
    repeat (520) tick();
    chk("next_count_f1", longint'(next_cnt), 64'd1);
    chk("words_consumed_f1", longint'(exp_words.size()), 64'd0);
    chk("idle_after_f1", longint'(busy), 64'd0);

    // output capture
    core_frame(-1);
    chk("err_clean", longint'(err_overlap), 64'd0);
    chk("m_hold_valid", longint'(bus.m_valid), 64'd0);
    chk("m_hold_re0", longint'(bus.m_re0), longint'(4 * (PAIRS - 1)));
    chk("m_hold_bin", longint'(bus.m_bin), longint'(PAIRS - 1));

    // enable pause mid-fill
    pat = 1;
    base = next_cnt;
    feed(300, 1000);
    enable = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("pause_s_ready", longint'(bus.s_ready), 64'd0);
    end
    chk("pause_busy", longint'(busy), 64'd1);
    chk("pause_no_next", longint'(next_cnt), longint'(base));
    enable = 1'b1;
    feed(N_POINTS - 300, 2000);
    repeat (520) tick();
    chk("pause_one_next", longint'(next_cnt), longint'(base + 1));
    chk("words_consumed_f2", longint'(exp_words.size()), 64'd0);

    // overlapping core frame
    core_frame(100);
    chk("err_sticky", longint'(err_overlap), 64'd1);

    // reset in the middle of streaming
    feed(N_POINTS, 2000);
    for (int g = 0; g < 1000 && !(stream_on && k == 200); g++) tick();
    chk("reached_word_200", longint'(k), 64'd200);
    reset = 1'b0;
    tick();
    chk("abort_x_zero", longint'({fft_x3, fft_x2, fft_x1, fft_x0}), 64'd0);
    chk("abort_fft_reset", longint'(fft_reset), 64'd1);
    chk("abort_s_ready", longint'(bus.s_ready), 64'd0);
    chk("abort_err_clear", longint'(err_overlap), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("abort_fft_reset_hold", longint'(fft_reset), 64'd1);
    tick();
    chk("abort_fft_reset_low", longint'(fft_reset), 64'd0);
    chk("abort_m_valid", longint'(bus.m_valid), 64'd0);
    base = next_cnt;
    feed(N_POINTS, 2000);
    repeat (520) tick();
    chk("fresh_frame_next", longint'(next_cnt), longint'(base + 1));

    // three back-to-back frames
    last_next_cyc = -1;
    spacing_q.delete();
    low_runs.delete();
    low_run = 0;
    base = next_cnt;
    feed(3 * N_POINTS, 6000);
    repeat (520) tick();
    chk("cont_next_count", longint'(next_cnt), longint'(base + 3));
    chk("cont_spacing_n", longint'(spacing_q.size()), 64'd2);
    foreach (spacing_q[i]) chk("cont_spacing", longint'(spacing_q[i]), 64'd1537);
    chk("cont_lowrun_n", longint'(low_runs.size()), 64'd3);
    foreach (low_runs[i]) chk("cont_lowrun", longint'(low_runs[i]), 64'd513);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
